// File: rtl/alu_operand_arbiter_pkg.sv
// rtl/alu_operand_arbiter_pkg.sv - shared constants, state encoding and helpers for the operand arbiter
//
// Purpose: requester count, select width, FSM encoding, reset-pointer
// sanitising and one-hot helper shared by the arbiter, its interface and
// its priority picker.
// Ports: none (package).
package alu_operand_arbiter_pkg;

  localparam int N_REQ   = 8;
  localparam int SEL_W   = 3;
  localparam int PTR_MAX = N_REQ - 1;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // An out-of-range PTR_INIT falls back to requester 0 rather than
  // silently truncating to some other index.
  function automatic logic [SEL_W-1:0] ptr_reset_value(input int ptr_init);
    logic [31:0] raw;
    raw = ptr_init;
    if (ptr_init < 0 || ptr_init > PTR_MAX) return '0;
    return raw[SEL_W-1:0];
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] one;
    one = {{(N_REQ-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/alu_operand_arbiter_if.sv
// rtl/alu_operand_arbiter_if.sv - requester/ALU side bundle of the operand arbiter
//
// Purpose: groups the eight request lines and data words, the grant and
// select outputs, and the Y valid/ready handshake toward the ALU.
// Ports (signals):
//   Req[7:0]      requester i has a word on Di
//   D0..D7        requester data words, WIDTH bits each
//   Gnt[7:0]      one-hot capture pulse
//   Sel[2:0]      index of the word held in Y
//   Y             registered operand
//   YValid/YReady ALU handshake
//   Busy          status copy of YValid
// Modports: master = requesters + ALU side, slave = arbiter.
interface alu_operand_arbiter_if #(parameter int WIDTH = 32);
  import alu_operand_arbiter_pkg::*;

  logic [N_REQ-1:0] Req;
  logic [WIDTH-1:0] D0, D1, D2, D3, D4, D5, D6, D7;
  logic [N_REQ-1:0] Gnt;
  logic [SEL_W-1:0] Sel;
  logic [WIDTH-1:0] Y;
  logic             YValid;
  logic             YReady;
  logic             Busy;

  modport master (
    output Req, D0, D1, D2, D3, D4, D5, D6, D7, YReady,
    input  Gnt, Sel, Y, YValid, Busy
  );

  modport slave (
    input  Req, D0, D1, D2, D3, D4, D5, D6, D7, YReady,
    output Gnt, Sel, Y, YValid, Busy
  );

endinterface

// File: rtl/alu_operand_arbiter_rr_priority_pick.sv
// rtl/alu_operand_arbiter_rr_priority_pick.sv - combinational round-robin winner search
//
// Purpose: returns the first requester with req set, scanning from ptr
// upward modulo N_REQ.
// Ports:
//   req[7:0]     request vector
//   ptr[2:0]     highest-priority index this cycle
//   winner[2:0]  selected index (ptr when nothing is requesting)
//   any_req      at least one request is pending
module rr_priority_pick
  import alu_operand_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] winner,
  output logic             any_req
);

  logic [SEL_W-1:0] idx;

  // Scanning from the farthest offset down to offset 0 lets the last hit,
  // i.e. the one closest to ptr, win without a separate found flag.
  always_comb begin
    winner  = ptr;
    any_req = 1'b0;
    idx     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ptr + SEL_W'(k);
      if (req[idx]) begin
        winner  = idx;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/word_mux8.sv
// rtl/word_mux8.sv - 8:1 word multiplexer shared by the operand sources
//
// Purpose: selects one of eight WIDTH-bit words.
// Ports:
//   d0..d7    input words
//   sel[2:0]  select index
//   y         selected word
module word_mux8 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [WIDTH-1:0] d4,
  input  logic [WIDTH-1:0] d5,
  input  logic [WIDTH-1:0] d6,
  input  logic [WIDTH-1:0] d7,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = d0;
    case (sel)
      3'd0: y = d0;
      3'd1: y = d1;
      3'd2: y = d2;
      3'd3: y = d3;
      3'd4: y = d4;
      3'd5: y = d5;
      3'd6: y = d6;
      3'd7: y = d7;
      default: y = d0;
    endcase
  end

endmodule

// File: rtl/alu_operand_arbiter.sv
// rtl/alu_operand_arbiter.sv - round-robin owner of the shared ALU operand mux
//
// Purpose: picks one of eight requesters per transaction, captures its
// word into Y and offers it to the ALU with a valid/ready handshake.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    alu_operand_arbiter_if.slave (Req, D0..D7, Gnt, Sel, Y,
//          YValid, YReady, Busy)
// Parameters: WIDTH data width, PTR_INIT round-robin pointer after reset.
module alu_operand_arbiter
  import alu_operand_arbiter_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int PTR_INIT = 0
) (
  input logic                 clk,
  input logic                 reset,
  alu_operand_arbiter_if.slave bus
);

  localparam logic [SEL_W-1:0] PTR_RST = ptr_reset_value(PTR_INIT);

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] winner;
  logic [SEL_W-1:0] sel_q;
  logic [N_REQ-1:0] gnt_q;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] mux_y;
  logic             any_req;
  logic             capture;

  rr_priority_pick u_pick (
    .req     (bus.Req),
    .ptr     (ptr),
    .winner  (winner),
    .any_req (any_req)
  );

  word_mux8 #(.WIDTH(WIDTH)) u_mux (
    .d0  (bus.D0),
    .d1  (bus.D1),
    .d2  (bus.D2),
    .d3  (bus.D3),
    .d4  (bus.D4),
    .d5  (bus.D5),
    .d6  (bus.D6),
    .d7  (bus.D7),
    .sel (winner),
    .y   (mux_y)
  );

  // A new word may be taken when Y is empty or being consumed this cycle;
  // the latter gives back-to-back captures with YReady held high.
  assign capture = ((state == IDLE) || bus.YReady) && any_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= PTR_RST;
      sel_q <= '0;
      gnt_q <= '0;
      y_q   <= '0;
    end else begin
      gnt_q <= '0;
      if (capture) begin
        state <= HOLD;
        y_q   <= mux_y;
        sel_q <= winner;
        gnt_q <= onehot(winner);
        ptr   <= winner + 3'd1;
      end else if (state == HOLD && bus.YReady) begin
        state <= IDLE;
      end
    end
  end

  assign bus.Gnt    = gnt_q;
  assign bus.Sel    = sel_q;
  assign bus.Y      = y_q;
  assign bus.YValid = (state == HOLD);
  assign bus.Busy   = (state == HOLD);

endmodule

// File: tb/tb_alu_operand_arbiter.sv
// tb/tb_alu_operand_arbiter.sv - self-checking bench for alu_operand_arbiter
module tb_alu_operand_arbiter;

  typedef struct {
    logic [7:0]  gnt;
    logic [2:0]  sel;
    logic [31:0] y;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  req;
  logic [31:0] d [8];
  logic        y_ready;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t q[$];

  logic [2:0]  m_ptr;
  logic        m_hold;
  logic [31:0] m_y;
  logic [2:0]  m_sel;

  alu_operand_arbiter_if #(.WIDTH(32)) bus ();

  assign bus.Req    = req;
  assign bus.YReady = y_ready;
  assign bus.D0 = d[0];
  assign bus.D1 = d[1];
  assign bus.D2 = d[2];
  assign bus.D3 = d[3];
  assign bus.D4 = d[4];
  assign bus.D5 = d[5];
  assign bus.D6 = d[6];
  assign bus.D7 = d[7];

  alu_operand_arbiter #(.WIDTH(32), .PTR_INIT(0)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Advances one clock; before the edge, predicts the capture from the
  // inputs now being driven and pushes it to the scoreboard.
  task automatic cycle();
    exp_t       e;
    logic [2:0] w;
    logic [2:0] idx;
    bit         found;
    if (rst) begin
      m_ptr  = 3'd0;
      m_hold = 1'b0;
      m_y    = 32'h0;
      m_sel  = 3'd0;
    end else if ((!m_hold || y_ready) && req != 8'h00) begin
      found = 1'b0;
      w     = 3'd0;
      for (int k = 0; k < 8; k++) begin
        idx = 3'(m_ptr + 3'(k));
        if (!found && req[idx]) begin
          found = 1'b1;
          w     = idx;
        end
      end
      e.gnt = 8'h01 << w;
      e.sel = w;
      e.y   = d[w];
      q.push_back(e);
      m_ptr  = w + 3'd1;
      m_hold = 1'b1;
      m_y    = d[w];
      m_sel  = w;
    end else if (m_hold && y_ready) begin
      m_hold = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fill_data();
    for (int i = 0; i < 8; i++) d[i] = $urandom();
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1; req = 8'hFF; y_ready = 1'b0;
    fill_data();
    for (int c = 0; c < 2; c++) begin
      cycle();
      n_cmp++;
      if (bus.Y !== 32'h0 || bus.YValid !== 1'b0 || bus.Gnt !== 8'h00 || bus.Sel !== 3'd0 || bus.Busy !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_state: Y=%h YValid=%b Gnt=%h Sel=%0d Busy=%b required all zero", bus.Y, bus.YValid, bus.Gnt, bus.Sel, bus.Busy);
      end
    end
    rst = 1'b0;
    cycle();
    n_cmp++;
    if (q.size() == 0) begin
      n_bad++;
      $display("FAIL reset_first_capture: no capture predicted");
    end else begin
      e = q.pop_front();
      if (bus.Gnt !== 8'h01 || e.gnt !== 8'h01 || bus.Sel !== 3'd0 || bus.Y !== d[0] || bus.YValid !== 1'b1) begin
        n_bad++;
        $display("FAIL reset_first_capture: Gnt=%h Sel=%0d Y=%h YValid=%b required Gnt=01 Sel=0 Y=%h YValid=1", bus.Gnt, bus.Sel, bus.Y, bus.YValid, d[0]);
      end
    end
    req = 8'h00; y_ready = 1'b1;
    cycle();
    n_cmp++;
    if (bus.YValid !== 1'b0 || bus.Gnt !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_drain: YValid=%b Gnt=%h required YValid=0 Gnt=00", bus.YValid, bus.Gnt);
    end
    y_ready = 1'b0;
  endtask

  task automatic test_single();
    exp_t e;
    req = 8'h08; d[3] = 32'hDEADBEEF; y_ready = 1'b0;
    cycle();
    n_cmp++;
    if (q.size() == 0) begin
      n_bad++;
      $display("FAIL single_capture: no capture predicted");
    end else begin
      e = q.pop_front();
      if (bus.Gnt !== e.gnt || bus.Sel !== 3'd3 || bus.Y !== 32'hDEADBEEF || bus.YValid !== 1'b1) begin
        n_bad++;
        $display("FAIL single_capture: Gnt=%h Sel=%0d Y=%h YValid=%b required Gnt=08 Sel=3 Y=deadbeef YValid=1", bus.Gnt, bus.Sel, bus.Y, bus.YValid);
      end
    end
    req = 8'h00; d[3] = 32'h0BADF00D;
    for (int c = 0; c < 5; c++) begin
      cycle();
      n_cmp++;
      if (bus.Y !== 32'hDEADBEEF || bus.Sel !== 3'd3 || bus.YValid !== 1'b1 || bus.Gnt !== 8'h00 || bus.Busy !== 1'b1) begin
        n_bad++;
        $display("FAIL single_stall: Y=%h Sel=%0d YValid=%b Gnt=%h required Y=deadbeef Sel=3 YValid=1 Gnt=00", bus.Y, bus.Sel, bus.YValid, bus.Gnt);
      end
    end
    y_ready = 1'b1;
    cycle();
    n_cmp++;
    if (bus.YValid !== 1'b0 || bus.Busy !== 1'b0 || bus.Gnt !== 8'h00) begin
      n_bad++;
      $display("FAIL single_release: YValid=%b Busy=%b Gnt=%h required 0 0 00", bus.YValid, bus.Busy, bus.Gnt);
    end
    y_ready = 1'b0;
  endtask

  task automatic test_round_robin();
    exp_t e;
    int   cnt [8];
    y_ready = 1'b1; req = 8'h81;
    for (int c = 0; c < 13; c++) begin
      if (c == 4) req = 8'hFF;
      if (c == 4) for (int i = 0; i < 8; i++) cnt[i] = 0;
      fill_data();
      cycle();
      n_cmp++;
      if (q.size() == 0 || bus.Gnt === 8'h00) begin
        n_bad++;
        $display("FAIL rr_capture: Gnt=%h queued=%0d required one grant per cycle", bus.Gnt, q.size());
        q.delete();
      end else begin
        e = q.pop_front();
        if (bus.Gnt !== e.gnt || bus.Sel !== e.sel || bus.Y !== e.y) begin
          n_bad++;
          $display("FAIL rr_capture: Gnt=%h Sel=%0d Y=%h required Gnt=%h Sel=%0d Y=%h", bus.Gnt, bus.Sel, bus.Y, e.gnt, e.sel, e.y);
        end
      end
      if (c >= 4 && c < 12) for (int i = 0; i < 8; i++) if (bus.Gnt[i] === 1'b1) cnt[i]++;
    end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (cnt[i] != 1) begin
        n_bad++;
        $display("FAIL rr_fairness: requester %0d granted %0d times in 8 captures, required 1", i, cnt[i]);
      end
    end
    req = 8'h00;
    cycle();
    n_cmp++;
    if (bus.YValid !== 1'b0 || bus.Gnt !== 8'h00) begin
      n_bad++;
      $display("FAIL rr_drain: YValid=%b Gnt=%h required 0 00", bus.YValid, bus.Gnt);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [7:0] prev;
    prev = 8'h00;
    y_ready = 1'b1; req = 8'h06;
    for (int c = 0; c < 8; c++) begin
      fill_data();
      cycle();
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL b2b_capture: no capture predicted");
      end else begin
        e = q.pop_front();
        if (bus.Gnt !== e.gnt || bus.Y !== e.y || bus.YValid !== 1'b1 || !(bus.Gnt == 8'h02 || bus.Gnt == 8'h04) || bus.Gnt === prev) begin
          n_bad++;
          $display("FAIL b2b_capture: Gnt=%h Y=%h YValid=%b prev=%h required Gnt=%h Y=%h YValid=1", bus.Gnt, bus.Y, bus.YValid, prev, e.gnt, e.y);
        end
      end
      prev = bus.Gnt;
    end
    req = 8'h00;
    cycle();
    y_ready = 1'b0;
    n_cmp++;
    if (bus.YValid !== 1'b0 || q.size() != 0) begin
      n_bad++;
      $display("FAIL b2b_drain: YValid=%b queued=%0d required 0 0", bus.YValid, q.size());
    end
  endtask

  task automatic test_withdrawal();
    exp_t e;
    bit   saw5;
    saw5 = 1'b0;
    y_ready = 1'b0; req = 8'h08;
    fill_data();
    cycle();
    if (q.size() != 0) e = q.pop_front();
    req = 8'h30;
    for (int c = 0; c < 6; c++) begin
      if (c == 2) req = 8'h10;
      if (c == 3) y_ready = 1'b1;
      if (c == 4) req = 8'h40;
      if (c == 5) req = 8'h00;
      cycle();
      if (bus.Gnt[5] === 1'b1) saw5 = 1'b1;
      n_cmp++;
      if (bus.Gnt !== 8'h00) begin
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL wd_grant_unexpected: Gnt=%h required 00", bus.Gnt);
        end else begin
          e = q.pop_front();
          if (bus.Gnt !== e.gnt || bus.Sel !== e.sel || bus.Y !== e.y) begin
            n_bad++;
            $display("FAIL wd_capture: Gnt=%h Sel=%0d Y=%h required Gnt=%h Sel=%0d Y=%h", bus.Gnt, bus.Sel, bus.Y, e.gnt, e.sel, e.y);
          end
        end
      end else if (q.size() != 0) begin
        n_bad++;
        $display("FAIL wd_missing_grant: Gnt=00 required %h", q[0].gnt);
        q.delete();
      end
      n_cmp++;
      if (bus.YValid !== m_hold || bus.Y !== m_y || bus.Sel !== m_sel) begin
        n_bad++;
        $display("FAIL wd_state: YValid=%b Y=%h Sel=%0d required YValid=%b Y=%h Sel=%0d", bus.YValid, bus.Y, bus.Sel, m_hold, m_y, m_sel);
      end
    end
    n_cmp++;
    if (saw5) begin
      n_bad++;
      $display("FAIL wd_skip5: Gnt[5] pulsed=1 required 0");
    end
    y_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    req = 8'h04; d[2] = 32'h12345678; y_ready = 1'b0;
    cycle();
    if (q.size() != 0) e = q.pop_front();
    req = 8'h00;
    cycle();
    n_cmp++;
    if (bus.YValid !== 1'b1 || bus.Y !== 32'h12345678) begin
      n_bad++;
      $display("FAIL rmid_setup: YValid=%b Y=%h required 1 12345678", bus.YValid, bus.Y);
    end
    rst = 1'b1; req = 8'h03;
    cycle();
    n_cmp++;
    if (bus.YValid !== 1'b0 || bus.Y !== 32'h0 || bus.Gnt !== 8'h00 || bus.Sel !== 3'd0) begin
      n_bad++;
      $display("FAIL rmid_reset: YValid=%b Y=%h Gnt=%h Sel=%0d required 0 0 00 0", bus.YValid, bus.Y, bus.Gnt, bus.Sel);
    end
    rst = 1'b0; y_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      fill_data();
      cycle();
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL rmid_regrant: no capture predicted");
      end else begin
        e = q.pop_front();
        if (bus.Gnt !== e.gnt || bus.Y !== e.y || bus.Gnt !== ((c % 2 == 0) ? 8'h01 : 8'h02)) begin
          n_bad++;
          $display("FAIL rmid_regrant: Gnt=%h Y=%h required Gnt=%h Y=%h", bus.Gnt, bus.Y, e.gnt, e.y);
        end
      end
    end
    req = 8'h00;
    cycle();
    y_ready = 1'b0;
  endtask

  initial begin
    m_ptr = 3'd0; m_hold = 1'b0; m_y = 32'h0; m_sel = 3'd0;
    rst = 1'b1; req = 8'h00; y_ready = 1'b0;
    for (int i = 0; i < 8; i++) d[i] = 32'h0;
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_withdrawal();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
